l2_port_arbiter: RTL

- Shares the single L1-side port of the L2 cache between two L1 requesters: port 0 is the instruction L1 and port 1 is the data L1.
- Performs round-robin arbitration and keeps one transaction outstanding at a time.
- Holds the address, write data and command stable for the whole L2 transaction, then routes the response back to the granted requester.
- A watchdog aborts any transaction the L2 never completes.

---
 rtl/l2_port_arbiter.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/l2_port_arbiter.sv
// l2_port_arbiter: shares the L2's single L1-side port between the instruction
// L1 (port 0) and the data L1 (port 1). Round-robin grant, one transaction in
// flight, request fields frozen for the whole L2 access, response steered back
// to the granted port, and a watchdog that aborts an access the L2 never
// completes.
module l2_port_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 256,
    parameter int CNT_WIDTH  = 9
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] p0_addr,
    input  logic [DATA_WIDTH-1:0] p0_wdata,
    input  logic                  p0_read,
    input  logic                  p0_write,
    output logic [DATA_WIDTH-1:0] p0_rdata,
    output logic                  p0_ready,
    output logic                  p0_hit,
    output logic                  p0_err,
    input  logic [ADDR_WIDTH-1:0] p1_addr,
    input  logic [DATA_WIDTH-1:0] p1_wdata,
    input  logic                  p1_read,
    input  logic                  p1_write,
    output logic [DATA_WIDTH-1:0] p1_rdata,
    output logic                  p1_ready,
    output logic                  p1_hit,
    output logic                  p1_err,
    output logic [ADDR_WIDTH-1:0] l2_addr,
    output logic [DATA_WIDTH-1:0] l2_wdata,
    output logic                  l2_read,
    output logic                  l2_write,
    input  logic [DATA_WIDTH-1:0] l2_rdata,
    input  logic                  l2_ready,
    input  logic                  l2_hit,
    output logic                  busy,
    output logic                  grant_id
);

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    // Request fields of whichever port wins arbitration this cycle.
    typedef struct packed {
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] wdata;
        logic                  wr;
    } req_t;

    // Watchdog fires on its last count so exactly TIMEOUT BUSY cycles elapse.
    localparam logic [CNT_WIDTH-1:0] WD_LAST = CNT_WIDTH'(TIMEOUT - 1);

    state_t               state;
    logic [CNT_WIDTH-1:0] wdog;
    logic                 rr_last;   // port granted most recently; reset to 1 so port 0 wins first
    logic [1:0]           req;
    logic                 pick;
    req_t                 sel;

    assign req = {p1_read | p1_write, p0_read | p0_write};

    // Round-robin pick and mux of the winning port's request; write wins over read.
    always_comb begin
        pick = 1'b0;
        if (req == 2'b11)
            pick = ~rr_last;
        else if (req == 2'b10)
            pick = 1'b1;
        if (pick)
            sel = '{addr: p1_addr, wdata: p1_wdata, wr: p1_write};
        else
            sel = '{addr: p0_addr, wdata: p0_wdata, wr: p0_write};
    end

    // Arbitration FSM with all outputs registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            wdog     <= '0;
            rr_last  <= 1'b1;
            busy     <= 1'b0;
            grant_id <= 1'b0;
            l2_addr  <= '0;
            l2_wdata <= '0;
            l2_read  <= 1'b0;
            l2_write <= 1'b0;
            p0_rdata <= '0;
            p0_hit   <= 1'b0;
            p0_ready <= 1'b0;
            p0_err   <= 1'b0;
            p1_rdata <= '0;
            p1_hit   <= 1'b0;
            p1_ready <= 1'b0;
            p1_err   <= 1'b0;
        end else begin
            p0_ready <= 1'b0;
            p0_err   <= 1'b0;
            p1_ready <= 1'b0;
            p1_err   <= 1'b0;
            case (state)
                IDLE: begin
                    if (|req) begin
                        l2_addr  <= sel.addr;
                        l2_wdata <= sel.wdata;
                        l2_write <= sel.wr;
                        l2_read  <= ~sel.wr;
                        grant_id <= pick;
                        wdog     <= '0;
                        busy     <= 1'b1;
                        state    <= BUSY;
                    end
                end
                BUSY: begin
                    if (l2_ready) begin
                        if (grant_id) begin
                            p1_ready <= 1'b1;
                            p1_rdata <= l2_rdata;
                            p1_hit   <= l2_hit;
                        end else begin
                            p0_ready <= 1'b1;
                            p0_rdata <= l2_rdata;
                            p0_hit   <= l2_hit;
                        end
                        l2_read  <= 1'b0;
                        l2_write <= 1'b0;
                        rr_last  <= grant_id;
                        state    <= RESP;
                    end else if (wdog == WD_LAST) begin
                        if (grant_id)
                            p1_err <= 1'b1;
                        else
                            p0_err <= 1'b1;
                        l2_read  <= 1'b0;
                        l2_write <= 1'b0;
                        rr_last  <= grant_id;
                        state    <= RESP;
                    end else begin
                        wdog <= wdog + 1'b1;
                    end
                end
                RESP: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
